// File: rtl/signext.sv
`default_nettype none
// ============================================================================
// Module   : signext
// Purpose  : Immediate extension unit. Widens a 16-bit immediate to 32 bits
//            using one of six extension operations (sign/zero extend from 16
//            or 8 bits, load-upper, branch offset). Illegal operation codes
//            produce zero and raise err. Outputs are optionally registered.
// Ports    : clk     - rising-edge clock
//            reset   - asynchronous active-high reset
//            en      - load enable for the output registers
//            mode    - [2:0] extension operation select
//            imm     - [15:0] immediate field
//            extdimm - [31:0] extended immediate
//            valid   - extdimm holds a result loaded since reset
//            err     - last loaded mode was illegal
// Params   : REG_OUT - 1: registered outputs (1-cycle latency)
//                      0: combinational outputs (clk/reset/en unused)
// Revision : 1.0 - initial release
// ============================================================================
module signext #(
  parameter int REG_OUT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [2:0]  mode,
  input  logic [15:0] imm,
  output logic [31:0] extdimm,
  output logic        valid,
  output logic        err
);

  localparam logic [2:0] c_MODE_SEXT   = 3'b000;
  localparam logic [2:0] c_MODE_ZEXT   = 3'b001;
  localparam logic [2:0] c_MODE_LUI    = 3'b010;
  localparam logic [2:0] c_MODE_BRANCH = 3'b011;
  localparam logic [2:0] c_MODE_SEXT8  = 3'b100;
  localparam logic [2:0] c_MODE_ZEXT8  = 3'b101;

  logic [31:0] w_result;
  logic        w_err;

  // Pure replication/concatenation; X on imm propagates straight through.
  always_comb begin
    w_result = 32'h0000_0000;
    w_err    = 1'b0;
    case (mode)
      c_MODE_SEXT:   w_result = {{16{imm[15]}}, imm};
      c_MODE_ZEXT:   w_result = {16'h0000, imm};
      c_MODE_LUI:    w_result = {imm, 16'h0000};
      c_MODE_BRANCH: w_result = {{14{imm[15]}}, imm, 2'b00};
      c_MODE_SEXT8:  w_result = {{24{imm[7]}}, imm[7:0]};
      c_MODE_ZEXT8:  w_result = {24'h00_0000, imm[7:0]};
      default: begin
        w_result = 32'h0000_0000;
        w_err    = 1'b1;
      end
    endcase
  end

  generate
    if (REG_OUT != 0) begin : g_reg_out
      logic [31:0] r_extdimm;
      logic        r_valid;
      logic        r_err;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_extdimm <= 32'h0000_0000;
          r_valid   <= 1'b0;
          r_err     <= 1'b0;
        end else if (en) begin
          r_extdimm <= w_result;
          r_valid   <= 1'b1;
          r_err     <= w_err;
        end
      end

      assign extdimm = r_extdimm;
      assign valid   = r_valid;
      assign err     = r_err;
    end else begin : g_comb_out
      assign extdimm = w_result;
      assign valid   = 1'b1;
      assign err     = w_err;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_signext.sv
`default_nettype none
// ============================================================================
// Module   : tb_signext
// Purpose  : Self-checking bench for signext (REG_OUT=1). A reference model
//            computes the extension with plain integer arithmetic and tracks
//            the expected registered outputs; a compare process checks the
//            DUT every cycle, and directed vectors pin literal results.
// Revision : 1.0 - initial release
// ============================================================================
module tb_signext;

  logic        clk;
  logic        reset;
  logic        en;
  logic [2:0]  mode;
  logic [15:0] imm;
  logic [31:0] extdimm;
  logic        valid;
  logic        err;

  int total = 0;
  int bad   = 0;
  bit run_chk = 1'b0;

  signext #(.REG_OUT(1)) dut (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .mode    (mode),
    .imm     (imm),
    .extdimm (extdimm),
    .valid   (valid),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference extension: arithmetic view (sign extension via signed ints,
  // shifts via multiplication). Bit 32 carries the illegal-mode flag.
  function automatic logic [32:0] model(input logic [2:0] m, input logic [15:0] i);
    int          s16;
    byte         b8;
    int          s8;
    logic [31:0] v;
    logic        e;
    s16 = int'($signed(i));
    b8  = byte'(i[7:0]);
    s8  = int'(b8);
    e   = 1'b0;
    case (m)
      3'd0:    v = 32'(s16);
      3'd1:    v = 32'(i);
      3'd2:    v = 32'(i) * 32'd65536;
      3'd3:    v = 32'(s16 * 4);
      3'd4:    v = 32'(s8);
      3'd5:    v = 32'(i) % 32'd256;
      default: begin v = 32'd0; e = 1'b1; end
    endcase
    return {e, v};
  endfunction

  // Expected register state.
  logic [31:0] m_ext;
  logic        m_valid;
  logic        m_err;

  always @(posedge clk or posedge reset) begin
    logic [32:0] r;
    if (reset) begin
      m_ext   = 32'd0;
      m_valid = 1'b0;
      m_err   = 1'b0;
    end else if (en) begin
      r       = model(mode, imm);
      m_ext   = r[31:0];
      m_err   = r[32];
      m_valid = 1'b1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (run_chk) begin
      chk("cyc_extdimm", extdimm, m_ext);
      chk("cyc_valid", {31'd0, valid}, {31'd0, m_valid});
      chk("cyc_err", {31'd0, err}, {31'd0, m_err});
    end
  end

  task automatic drive(input logic e, input logic [2:0] m, input logic [15:0] i);
    @(posedge clk);
    #2;
    en   = e;
    mode = m;
    imm  = i;
  endtask

  typedef struct {
    logic [2:0]  m;
    logic [15:0] i;
    logic [31:0] x;
    logic        e;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [32:0] pin;

    reset = 1'b1;
    en    = 1'b0;
    mode  = 3'd0;
    imm   = 16'd0;

    // Model pins against hand-computed values.
    pin = model(3'd3, 16'hFFFF); chk("pin_branch_neg", pin[31:0], 32'hFFFF_FFFC);
    pin = model(3'd4, 16'h1280); chk("pin_sext8", pin[31:0], 32'hFFFF_FF80);
    pin = model(3'd6, 16'h1234); chk("pin_illegal", {31'd0, pin[32]}, 32'd1);

    repeat (2) @(posedge clk);
    #1;
    chk("rst_extdimm", extdimm, 32'd0);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    run_chk = 1'b1;

    // Edges under reset with en=1 must not load.
    en = 1'b1; mode = 3'd0; imm = 16'h0003;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hold_valid", {31'd0, valid}, 32'd0);
    @(posedge clk);
    #2 reset = 1'b0;
    @(posedge clk);
    #1;
    chk("first_load", extdimm, 32'h0000_0003);
    chk("first_valid", {31'd0, valid}, 32'd1);
    chk("first_err", {31'd0, err}, 32'd0);

    vecs.push_back('{3'd0, 16'h8001, 32'hFFFF_8001, 1'b0});
    vecs.push_back('{3'd1, 16'h8001, 32'h0000_8001, 1'b0});
    vecs.push_back('{3'd2, 16'h1234, 32'h1234_0000, 1'b0});
    vecs.push_back('{3'd3, 16'hFFFF, 32'hFFFF_FFFC, 1'b0});
    vecs.push_back('{3'd3, 16'h0004, 32'h0000_0010, 1'b0});
    vecs.push_back('{3'd4, 16'h1280, 32'hFFFF_FF80, 1'b0});
    vecs.push_back('{3'd5, 16'h1280, 32'h0000_0080, 1'b0});
    vecs.push_back('{3'd0, 16'h7FFF, 32'h0000_7FFF, 1'b0});
    vecs.push_back('{3'd4, 16'hFF7F, 32'h0000_007F, 1'b0});
    vecs.push_back('{3'd6, 16'hFFFF, 32'h0000_0000, 1'b1});
    vecs.push_back('{3'd2, 16'hFFFF, 32'hFFFF_0000, 1'b0});
    vecs.push_back('{3'd7, 16'h1234, 32'h0000_0000, 1'b1});

    foreach (vecs[k]) begin
      drive(1'b1, vecs[k].m, vecs[k].i);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_ext", k), extdimm, vecs[k].x);
      chk($sformatf("vec%0d_err", k), {31'd0, err}, {31'd0, vecs[k].e});
    end

    // Hold with en=0 after the illegal load.
    drive(1'b0, 3'd0, 16'h0003);
    repeat (2) @(posedge clk);
    #1;
    chk("hold_ext", extdimm, 32'd0);
    chk("hold_err", {31'd0, err}, 32'd1);
    chk("hold_valid", {31'd0, valid}, 32'd1);

    // Asynchronous reset between edges discards the held result.
    drive(1'b1, 3'd0, 16'h0003);
    @(posedge clk);
    #1;
    chk("pre_async_ext", extdimm, 32'h0000_0003);
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    chk("async_ext", extdimm, 32'd0);
    chk("async_valid", {31'd0, valid}, 32'd0);
    @(posedge clk);
    #2 reset = 1'b0;
    en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("post_rst_idle_valid", {31'd0, valid}, 32'd0);
    drive(1'b1, 3'd1, 16'hFFFF);
    @(posedge clk);
    #1;
    chk("post_rst_load", extdimm, 32'h0000_FFFF);

    @(negedge clk);
    run_chk = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
